// File: rtl/nx_line_buf_pkg.sv
// -----------------------------------------------------------------------------
// nx_line_buf_pkg
// Shared definitions for the NanEye multi-page line-buffer write controller:
// write-state encoding, LINE_STATUS bit positions, counter widths and the
// saturating increment used by the drop counter.
// -----------------------------------------------------------------------------
package nx_line_buf_pkg;

    // Write controller states.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DROP   = 2'd2
    } wr_state_t;

    // LINE_STATUS bit positions.
    localparam int ST_LONG   = 2;
    localparam int ST_SHORT  = 1;
    localparam int ST_PIXERR = 0;

    // Width of DROP_CNT and of the line counter / READY_LINE.
    localparam int DROP_CNT_W = 16;
    localparam int LINE_CNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        logic [DROP_CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + DROP_CNT_W'(1'b1);
        end
        return r;
    endfunction

endpackage

// File: rtl/nx_page_ring_cnt.sv
// -----------------------------------------------------------------------------
// nx_page_ring_cnt
// Write-page pointer and occupancy counter for the ring of 2**C_PAGE_W line
// pages. A commit advances the pointer and claims a page; a release frees the
// oldest page. Commit and release together leave occupancy unchanged; a
// release with no page owned is ignored.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   commit        a line is committed to the current write page
//   rd_release    reader freed the oldest page
//   wr_page       current write page
//   used          committed, unreleased pages (registered)
//   full_next     occupancy after this cycle's events equals the page count
// -----------------------------------------------------------------------------
module nx_page_ring_cnt #(
    parameter int C_PAGE_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                commit,
    input  logic                rd_release,
    output logic [C_PAGE_W-1:0] wr_page,
    output logic [C_PAGE_W:0]   used,
    output logic                full_next
);

    localparam logic [C_PAGE_W:0]   PAGES_L   = (C_PAGE_W+1)'(32'd1 << C_PAGE_W);
    localparam logic [C_PAGE_W:0]   USED_ZERO = (C_PAGE_W+1)'(1'b0);
    localparam logic [C_PAGE_W:0]   USED_ONE  = (C_PAGE_W+1)'(1'b1);
    localparam logic [C_PAGE_W-1:0] PAGE_ZERO = C_PAGE_W'(1'b0);
    localparam logic [C_PAGE_W-1:0] PAGE_ONE  = C_PAGE_W'(1'b1);

    logic [C_PAGE_W-1:0] wr_page_r;
    logic [C_PAGE_W:0]   used_r;
    logic [C_PAGE_W:0]   used_next_s;
    logic                rel_ok_s;

    // Net occupancy after this cycle's commit/release events.
    always_comb begin
        rel_ok_s = rd_release && (used_r != USED_ZERO);
        case ({commit, rel_ok_s})
            2'b10:   used_next_s = used_r + USED_ONE;
            2'b01:   used_next_s = used_r - USED_ONE;
            default: used_next_s = used_r;
        endcase
        full_next = (used_next_s == PAGES_L);
    end

    // Pointer and occupancy registers; the pointer wraps naturally mod pages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_page_r <= PAGE_ZERO;
            used_r    <= USED_ZERO;
        end else begin
            if (commit) begin
                wr_page_r <= wr_page_r + PAGE_ONE;
            end
            used_r <= used_next_s;
        end
    end

    assign wr_page = wr_page_r;
    assign used    = used_r;

endmodule

// File: rtl/nx_line_buf_wr_ctrl.sv
// -----------------------------------------------------------------------------
// nx_line_buf_wr_ctrl
// Writes deserialised pixels into a multi-page line-buffer DPRAM. Lines go to
// a ring of 2**C_PAGE_W pages released by the reader; with no free page a
// whole line is dropped. Line length and line count are checked.
// Ports:
//   CLOCK, RESET             sample clock, asynchronous active-high reset
//   FRAME_SYNC, LINE_SYNC    frame start / line end pulses
//   PULSE, PIXEL_ERROR       pixel strobe and its error qualifier
//   PIX_IN                   pixel data
//   RD_RELEASE               reader freed the oldest page
//   DPRAM_WR_ADDR/WE/DATA    DPRAM write port, {page, pixel index}
//   LINE_READY + READY_PAGE/READY_LINE/LINE_STATUS   line commit report
//   LINE_DROPPED, DROP_CNT   dropped-line pulse and per-frame count
//   PAGES_USED               committed, unreleased pages
//   FRAME_DONE               C_LINES lines handled
// All outputs are registered.
// -----------------------------------------------------------------------------
module nx_line_buf_wr_ctrl
    import nx_line_buf_pkg::*;
#(
    parameter int C_ADDR_W      = 9,
    parameter int C_PAGE_W      = 2,
    parameter int C_DATA_W      = 10,
    parameter int C_LINE_PIXELS = 250,
    parameter int C_LINES       = 250
) (
    input  logic                         CLOCK,
    input  logic                         RESET,
    input  logic                         FRAME_SYNC,
    input  logic                         LINE_SYNC,
    input  logic                         PULSE,
    input  logic                         PIXEL_ERROR,
    input  logic [C_DATA_W-1:0]          PIX_IN,
    input  logic                         RD_RELEASE,
    output logic [C_PAGE_W+C_ADDR_W-1:0] DPRAM_WR_ADDR,
    output logic                         DPRAM_WE,
    output logic [C_DATA_W-1:0]          DPRAM_DATA,
    output logic                         LINE_READY,
    output logic [C_PAGE_W-1:0]          READY_PAGE,
    output logic [LINE_CNT_W-1:0]        READY_LINE,
    output logic [2:0]                   LINE_STATUS,
    output logic                         LINE_DROPPED,
    output logic [DROP_CNT_W-1:0]        DROP_CNT,
    output logic [C_PAGE_W:0]            PAGES_USED,
    output logic                         FRAME_DONE
);

    localparam logic [C_ADDR_W:0]   PIX_ZERO   = (C_ADDR_W+1)'(1'b0);
    localparam logic [C_ADDR_W:0]   PIX_ONE    = (C_ADDR_W+1)'(1'b1);
    localparam logic [C_ADDR_W:0]   LINE_PIX_L = (C_ADDR_W+1)'(C_LINE_PIXELS);
    localparam logic [LINE_CNT_W-1:0] LINE_ONE = LINE_CNT_W'(1'b1);
    localparam logic [LINE_CNT_W-1:0] LINES_L  = LINE_CNT_W'(C_LINES);

    wr_state_t state_r, state_nxt_s;

    // Per-line tracking; pix_cnt is one bit wider so a full page can be counted.
    logic [C_ADDR_W:0]       pix_cnt_r;
    logic                    long_r;
    logic                    err_r;
    logic [LINE_CNT_W-1:0]   line_cnt_r;
    logic [DROP_CNT_W-1:0]   drop_cnt_r;

    // Registered outputs.
    logic                         we_r;
    logic [C_PAGE_W+C_ADDR_W-1:0] addr_r;
    logic [C_DATA_W-1:0]          data_r;
    logic                         line_ready_r;
    logic [C_PAGE_W-1:0]          ready_page_r;
    logic [LINE_CNT_W-1:0]        ready_line_r;
    logic [2:0]                   status_r;
    logic                         dropped_r;
    logic                         frame_done_r;

    // Decode.
    logic                  pix_ok_s, act_pulse_s, write_s;
    logic [C_ADDR_W:0]     cnt_eff_s;
    logic                  long_eff_s, err_eff_s;
    logic                  commit_s, drop_s, line_end_s, frame_end_s;
    logic [LINE_CNT_W-1:0] line_cnt_inc_s;
    logic [2:0]            status_s;
    logic [C_PAGE_W-1:0]   wr_page_s;
    logic [C_PAGE_W:0]     used_s;
    logic                  full_next_s;

    nx_page_ring_cnt #(
        .C_PAGE_W (C_PAGE_W)
    ) u_ring (
        .clk        (CLOCK),
        .rst        (RESET),
        .commit     (commit_s),
        .rd_release (RD_RELEASE),
        .wr_page    (wr_page_s),
        .used       (used_s),
        .full_next  (full_next_s)
    );

    // Pixel/line event decode. A pulse coincident with LINE_SYNC belongs to the
    // ending line, so the "effective" count and flags include it.
    always_comb begin
        pix_ok_s       = (pix_cnt_r < LINE_PIX_L);
        act_pulse_s    = (state_r == S_ACTIVE) && PULSE && !FRAME_SYNC;
        write_s        = act_pulse_s && pix_ok_s;
        cnt_eff_s      = write_s ? (pix_cnt_r + PIX_ONE) : pix_cnt_r;
        long_eff_s     = long_r || (act_pulse_s && !pix_ok_s);
        err_eff_s      = err_r || (act_pulse_s && PIXEL_ERROR);
        commit_s       = (state_r == S_ACTIVE) && LINE_SYNC && !FRAME_SYNC &&
                         ((cnt_eff_s != PIX_ZERO) || long_eff_s);
        drop_s         = (state_r == S_DROP) && LINE_SYNC && !FRAME_SYNC;
        line_end_s     = commit_s || drop_s;
        line_cnt_inc_s = line_cnt_r + LINE_ONE;
        frame_end_s    = line_end_s && (line_cnt_inc_s == LINES_L);
        status_s            = 3'b000;
        status_s[ST_LONG]   = long_eff_s;
        status_s[ST_SHORT]  = (cnt_eff_s < LINE_PIX_L);
        status_s[ST_PIXERR] = err_eff_s;
    end

    // Next-state logic; the free-page decision uses post-event occupancy.
    always_comb begin
        state_nxt_s = state_r;
        if (FRAME_SYNC) begin
            state_nxt_s = full_next_s ? S_DROP : S_ACTIVE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_nxt_s = S_IDLE;
                end
                S_ACTIVE, S_DROP: begin
                    if (!line_end_s) begin
                        state_nxt_s = state_r;
                    end else if (frame_end_s) begin
                        state_nxt_s = S_IDLE;
                    end else if (full_next_s) begin
                        state_nxt_s = S_DROP;
                    end else begin
                        state_nxt_s = S_ACTIVE;
                    end
                end
                default: begin
                    state_nxt_s = S_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Per-line pixel count/flags and per-frame line/drop counters.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            pix_cnt_r  <= PIX_ZERO;
            long_r     <= 1'b0;
            err_r      <= 1'b0;
            line_cnt_r <= LINE_CNT_W'(1'b0);
            drop_cnt_r <= DROP_CNT_W'(1'b0);
        end else if (FRAME_SYNC) begin
            pix_cnt_r  <= PIX_ZERO;
            long_r     <= 1'b0;
            err_r      <= 1'b0;
            line_cnt_r <= LINE_CNT_W'(1'b0);
            drop_cnt_r <= DROP_CNT_W'(1'b0);
        end else begin
            if (commit_s) begin
                pix_cnt_r <= PIX_ZERO;
                long_r    <= 1'b0;
                err_r     <= 1'b0;
            end else begin
                pix_cnt_r <= cnt_eff_s;
                long_r    <= long_eff_s;
                err_r     <= err_eff_s;
            end
            if (line_end_s) begin
                line_cnt_r <= line_cnt_inc_s;
            end
            if (drop_s) begin
                drop_cnt_r <= sat_inc(drop_cnt_r);
            end
        end
    end

    // DPRAM write port and line report registers.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            we_r         <= 1'b0;
            addr_r       <= (C_PAGE_W+C_ADDR_W)'(1'b0);
            data_r       <= C_DATA_W'(1'b0);
            line_ready_r <= 1'b0;
            ready_page_r <= C_PAGE_W'(1'b0);
            ready_line_r <= LINE_CNT_W'(1'b0);
            status_r     <= 3'b000;
            dropped_r    <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            we_r         <= write_s;
            line_ready_r <= commit_s;
            dropped_r    <= drop_s;
            frame_done_r <= frame_end_s;
            if (write_s) begin
                addr_r <= {wr_page_s, pix_cnt_r[C_ADDR_W-1:0]};
                data_r <= PIX_IN;
            end
            if (commit_s) begin
                ready_page_r <= wr_page_s;
                ready_line_r <= line_cnt_r;
                status_r     <= status_s;
            end
        end
    end

    assign DPRAM_WE      = we_r;
    assign DPRAM_WR_ADDR = addr_r;
    assign DPRAM_DATA    = data_r;
    assign LINE_READY    = line_ready_r;
    assign READY_PAGE    = ready_page_r;
    assign READY_LINE    = ready_line_r;
    assign LINE_STATUS   = status_r;
    assign LINE_DROPPED  = dropped_r;
    assign DROP_CNT      = drop_cnt_r;
    assign PAGES_USED    = used_s;
    assign FRAME_DONE    = frame_done_r;

endmodule

// File: tb/tb_nx_line_buf_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nx_line_buf_wr_ctrl
// Scoreboard bench: a line/page reference model (FIFO of owned pages, list of
// pixels in the current line) predicts every cycle's outputs when stimulus is
// applied; a monitor compares on each clock as the DUT presents them.
// -----------------------------------------------------------------------------
module tb_nx_line_buf_wr_ctrl;

    localparam int AW    = 3;
    localparam int PW    = 1;
    localparam int DW    = 8;
    localparam int LP    = 4;
    localparam int NL    = 3;
    localparam int PAGES = 1 << PW;

    logic          CLOCK_tb = 1'b0;
    logic          RESET_tb;
    logic          FRAME_SYNC_tb, LINE_SYNC_tb, PULSE_tb, PIXEL_ERROR_tb, RD_RELEASE_tb;
    logic [DW-1:0] PIX_IN_tb;
    logic [PW+AW-1:0] DPRAM_WR_ADDR_tb;
    logic          DPRAM_WE_tb;
    logic [DW-1:0] DPRAM_DATA_tb;
    logic          LINE_READY_tb;
    logic [PW-1:0] READY_PAGE_tb;
    logic [15:0]   READY_LINE_tb;
    logic [2:0]    LINE_STATUS_tb;
    logic          LINE_DROPPED_tb;
    logic [15:0]   DROP_CNT_tb;
    logic [PW:0]   PAGES_USED_tb;
    logic          FRAME_DONE_tb;

    nx_line_buf_wr_ctrl #(
        .C_ADDR_W(AW), .C_PAGE_W(PW), .C_DATA_W(DW), .C_LINE_PIXELS(LP), .C_LINES(NL)
    ) dut (
        .CLOCK(CLOCK_tb), .RESET(RESET_tb), .FRAME_SYNC(FRAME_SYNC_tb),
        .LINE_SYNC(LINE_SYNC_tb), .PULSE(PULSE_tb), .PIXEL_ERROR(PIXEL_ERROR_tb),
        .PIX_IN(PIX_IN_tb), .RD_RELEASE(RD_RELEASE_tb),
        .DPRAM_WR_ADDR(DPRAM_WR_ADDR_tb), .DPRAM_WE(DPRAM_WE_tb), .DPRAM_DATA(DPRAM_DATA_tb),
        .LINE_READY(LINE_READY_tb), .READY_PAGE(READY_PAGE_tb), .READY_LINE(READY_LINE_tb),
        .LINE_STATUS(LINE_STATUS_tb), .LINE_DROPPED(LINE_DROPPED_tb), .DROP_CNT(DROP_CNT_tb),
        .PAGES_USED(PAGES_USED_tb), .FRAME_DONE(FRAME_DONE_tb)
    );

    always #5 CLOCK_tb = ~CLOCK_tb;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    int  m_mode;          // 0 idle, 1 writing, 2 dropping
    int  m_owned[$];      // owned pages, oldest first
    int  m_next_page;
    int  m_cur_n;
    bit  m_long, m_err;
    int  m_line;
    int  m_drops;

    logic [PW+AW+DW-1:0] wr_q[$];
    logic [PW+16+3-1:0]  cm_q[$];
    logic [4+PW+1+16-1:0] cy_q[$];
    bit mon_en = 1'b0;

    task automatic model_reset();
        m_mode = 0; m_owned.delete(); m_next_page = 0; m_cur_n = 0;
        m_long = 1'b0; m_err = 1'b0; m_line = 0; m_drops = 0;
        wr_q.delete(); cm_q.delete(); cy_q.delete();
    endtask

    task automatic model_step(input bit fs, input bit ls, input bit pl, input bit pe,
                              input logic [DW-1:0] px, input bit rel);
        bit we = 1'b0, lr = 1'b0, dr = 1'b0, fd = 1'b0, line_end = 1'b0, rel_ok;
        logic [PW-1:0] pg;
        logic [AW-1:0] ad;
        logic [2:0]    st;
        rel_ok = rel && (m_owned.size() > 0);
        if (fs) begin
            m_cur_n = 0; m_long = 1'b0; m_err = 1'b0; m_line = 0; m_drops = 0;
        end else if (m_mode == 1) begin
            if (pl) begin
                if (m_cur_n < LP) begin
                    pg = PW'(m_next_page);
                    ad = AW'(m_cur_n);
                    wr_q.push_back({pg, ad, px});
                    we = 1'b1;
                    m_cur_n++;
                end else begin
                    m_long = 1'b1;
                end
                if (pe) m_err = 1'b1;
            end
            if (ls && (m_cur_n > 0 || m_long)) begin
                pg = PW'(m_next_page);
                st = {m_long, (m_cur_n < LP), m_err};
                cm_q.push_back({pg, 16'(m_line), st});
                m_owned.push_back(m_next_page);
                m_next_page = (m_next_page + 1) % PAGES;
                m_line++;
                lr = 1'b1; line_end = 1'b1;
                m_cur_n = 0; m_long = 1'b0; m_err = 1'b0;
            end
        end else if (m_mode == 2) begin
            if (ls) begin
                dr = 1'b1; line_end = 1'b1;
                m_line++;
                if (m_drops < 16'hFFFF) m_drops++;
            end
        end
        if (rel_ok) void'(m_owned.pop_front());
        if (fs) begin
            m_mode = (m_owned.size() < PAGES) ? 1 : 2;
        end else if (line_end) begin
            if (m_line == NL) begin
                fd = 1'b1; m_mode = 0;
            end else begin
                m_mode = (m_owned.size() < PAGES) ? 1 : 2;
            end
        end
        cy_q.push_back({we, lr, dr, fd, (PW+1)'(m_owned.size()), 16'(m_drops)});
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input bit fs, input bit ls, input bit pl, input bit pe,
                       input logic [DW-1:0] px, input bit rel);
        @(negedge CLOCK_tb);
        FRAME_SYNC_tb = fs; LINE_SYNC_tb = ls; PULSE_tb = pl;
        PIXEL_ERROR_tb = pe; PIX_IN_tb = px; RD_RELEASE_tb = rel;
        model_step(fs, ls, pl, pe, px, rel);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // n pixels (data 1..n), optional error pixel, LINE_SYNC separate or on the last pixel.
    task automatic send_line(input int n, input int err_idx, input bit merge, input bit rel);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, merge && (i == n-1), 1'b1, (i == err_idx), DW'(i + 1), rel && merge && (i == n-1));
        end
        if (!merge || n == 0) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, rel);
        idle(1);
    endtask

    // ---------------- monitor ----------------
    logic [4+PW+1+16-1:0] mon_e;
    always @(posedge CLOCK_tb) begin
        #1;
        if (mon_en && !RESET_tb && cy_q.size() > 0) begin
            mon_e = cy_q.pop_front();
            chk("flags_used_dropcnt",
                {DPRAM_WE_tb, LINE_READY_tb, LINE_DROPPED_tb, FRAME_DONE_tb, PAGES_USED_tb, DROP_CNT_tb},
                mon_e);
            if (DPRAM_WE_tb) begin
                if (wr_q.size() > 0) chk("write_addr_data", {DPRAM_WR_ADDR_tb, DPRAM_DATA_tb}, wr_q.pop_front());
                else chk("write_unexpected", DPRAM_WE_tb, 1'b0);
            end
            if (LINE_READY_tb) begin
                if (cm_q.size() > 0) chk("commit_page_line_status", {READY_PAGE_tb, READY_LINE_tb, LINE_STATUS_tb}, cm_q.pop_front());
                else chk("commit_unexpected", LINE_READY_tb, 1'b0);
            end
        end
    end

    task automatic chk_all_zero(input string name);
        chk(name, {DPRAM_WR_ADDR_tb, DPRAM_WE_tb, DPRAM_DATA_tb, LINE_READY_tb, READY_PAGE_tb,
                   READY_LINE_tb, LINE_STATUS_tb, LINE_DROPPED_tb, DROP_CNT_tb, FRAME_DONE_tb}, 64'd0);
        chk({name, "_pages_used"}, PAGES_USED_tb, 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        RESET_tb = 1'b1; FRAME_SYNC_tb = 1'b0; LINE_SYNC_tb = 1'b0; PULSE_tb = 1'b0;
        PIXEL_ERROR_tb = 1'b0; PIX_IN_tb = 8'h00; RD_RELEASE_tb = 1'b0;
        model_reset();
        repeat (3) @(posedge CLOCK_tb);
        #1;
        chk_all_zero("reset_state");
        @(negedge CLOCK_tb);
        RESET_tb = 1'b0;
        mon_en = 1'b1;

        // Pulses before any FRAME_SYNC are ignored.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        // Full line to page 0, then a second full line fills the ring,
        // third line dropped and ends the frame.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        send_line(4, -1, 1'b0, 1'b0);
        send_line(4, -1, 1'b1, 1'b0);
        send_line(4, -1, 1'b0, 1'b0);

        // New frame with ring full: dropped line, release coincident with its
        // LINE_SYNC reopens writing to page 0.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        send_line(4, -1, 1'b0, 1'b1);
        send_line(4, -1, 1'b0, 1'b1);

        // Short line then long line with a pixel error; zero-pixel LINE_SYNC ignored.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        send_line(3, -1, 1'b0, 1'b1);
        send_line(6, 1, 1'b0, 1'b1);

        // FRAME_SYNC mid-line discards it; LINE_SYNC with FRAME_SYNC ignored.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h21, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h22, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        send_line(2, 0, 1'b1, 1'b0);

        // Randomised traffic.
        for (int k = 0; k < 3000; k++) begin
            bit fs, ls, pl, pe, rl;
            fs = ($urandom_range(0, 59) == 0) || (m_mode == 0 && $urandom_range(0, 7) == 0);
            ls = ($urandom_range(0, 5) == 0);
            pl = !fs && ($urandom_range(0, 1) == 1);
            pe = ($urandom_range(0, 7) == 0);
            rl = ($urandom_range(0, 4) == 0);
            cyc(fs, ls, pl, pe, DW'($urandom), rl);
        end

        // Reset while a write is on the port.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 1'b0);
        @(posedge CLOCK_tb);
        #3;
        RESET_tb = 1'b1;
        mon_en = 1'b0;
        #1;
        chk_all_zero("async_reset");
        model_reset();
        @(negedge CLOCK_tb);
        PULSE_tb = 1'b1;
        @(negedge CLOCK_tb);
        RESET_tb = 1'b0;
        PULSE_tb = 1'b0;
        mon_en = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h66, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h67, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h68, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        send_line(4, -1, 1'b0, 1'b0);
        idle(3);

        chk("pending_writes", 64'(wr_q.size()), 64'd0);
        chk("pending_commits", 64'(cm_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nx_line_buf_wr_ctrl.md
Name: nx_line_buf_wr_ctrl

Overview:
Parametrised successor to the single-ping-pong DPRAM write controller in the NanEye receive path. It sits between RX_DESERIALIZER (pixel strobes, line/frame sync) and a multi-page line-buffer DPRAM. It manages a ring of 2**C_PAGE_W line pages with reader-release flow control, drops whole lines on overflow, and checks line length and line count. All logic is in the CLOCK (sample clock) domain; the reader release is synchronised upstream.

Parameters:
C_ADDR_W, 9, pixel address bits per page
C_PAGE_W, 2, log2 of page count (pages = 2**C_PAGE_W, min 1)
C_DATA_W, 10, pixel data width
C_LINE_PIXELS, 250, expected pixels per line (must be <= 2**C_ADDR_W)
C_LINES, 250, expected lines per frame

Ports:
CLOCK  in  1  sample clock
RESET  in  1  asynchronous, active-high reset
FRAME_SYNC  in  1  frame start pulse
LINE_SYNC  in  1  line end pulse
PULSE  in  1  pixel valid strobe
PIXEL_ERROR  in  1  qualifies PULSE: pixel decoded with error
PIX_IN  in  C_DATA_W  pixel data
RD_RELEASE  in  1  one-cycle pulse: reader freed the oldest page
DPRAM_WR_ADDR  out  C_PAGE_W+C_ADDR_W  {page, pixel index}
DPRAM_WE  out  1  write enable
DPRAM_DATA  out  C_DATA_W  write data
LINE_READY  out  1  one-cycle pulse: page committed
READY_PAGE  out  C_PAGE_W  page committed, valid with LINE_READY
READY_LINE  out  16  line index of committed page
LINE_STATUS  out  3  {long, short, pix_err}, valid with LINE_READY
LINE_DROPPED  out  1  one-cycle pulse: line discarded, no free page
DROP_CNT  out  16  dropped lines this frame, saturating
PAGES_USED  out  C_PAGE_W+1  committed, unreleased pages
FRAME_DONE  out  1  one-cycle pulse: C_LINES lines handled

Behaviour:
- Reset: every output is 0. State is IDLE. Write page, pixel count, line count and occupancy are 0.
- States:
  - IDLE: ignore PULSE and LINE_SYNC.
  - ACTIVE: writing a line.
  - DROP: discarding a line.
- FRAME_SYNC (any state, highest priority):
  - Discard the partial line. It is never committed.
  - Clear the line counter and DROP_CNT.
  - Go to ACTIVE if PAGES_USED < pages, else DROP.
  - A LINE_SYNC in the same cycle is ignored.
- ACTIVE, on PULSE:
  - If pix_cnt < C_LINE_PIXELS: register WE=1, ADDR={wr_page,pix_cnt}, DATA=PIX_IN (latency 1 cycle). Then pix_cnt++.
  - Otherwise: no write; set the line's long flag.
  - If PIXEL_ERROR=1: the pixel is still written and the address still advances; set the line's pix_err flag.
- ACTIVE, on LINE_SYNC with pix_cnt>0 or long flag set, commit the line on the next cycle:
  - LINE_READY=1 with READY_PAGE=wr_page, READY_LINE=line_cnt, LINE_STATUS; short = pix_cnt<C_LINE_PIXELS.
  - wr_page advances mod pages; PAGES_USED++; line_cnt++; clear pix_cnt and the flags.
  - Next line state is ACTIVE if post-update PAGES_USED < pages, else DROP.
- ACTIVE, on LINE_SYNC with zero pixels: ignore; nothing is counted.
- PULSE and LINE_SYNC in the same cycle: the pixel belongs to the ending line. Its WE and LINE_READY assert in the same cycle. LINE_READY never precedes that line's last WE.
- DROP:
  - PULSE produces no write.
  - On LINE_SYNC: LINE_DROPPED pulse, DROP_CNT++ (saturates at 0xFFFF), line_cnt++.
  - Re-evaluate free pages for the next line.
  - A page freed mid-line does not resume writing; no partial lines are committed.
- RD_RELEASE:
  - Decrements PAGES_USED.
  - Ignored when PAGES_USED=0.
  - Coincident with a commit: PAGES_USED is unchanged.
  - The free-page decision uses the net value.
- Frame end: when line_cnt reaches C_LINES (through a commit or a drop), FRAME_DONE pulses with that event and the state goes to IDLE. Pages stay owned until released.
- Read order: the reader reads pages in commit order; the ring guarantees FIFO order.
- Reset mid-line: abort immediately; no WE after RESET asserts.

Decomposition:
- Package nx_line_buf_pkg holds:
  - the state encoding (IDLE/ACTIVE/DROP);
  - LINE_STATUS bit indices (ST_LONG=2, ST_SHORT=1, ST_PIXERR=0);
  - the DROP_CNT width constant.
- Sub-module nx_page_ring_cnt holds the write-page pointer and occupancy counter: commit and release inputs, full/empty outputs, simultaneous-event rule.

Test Plan (C_PAGE_W=1, C_LINE_PIXELS=4, C_LINES=3 unless noted):
1. FRAME_SYNC, then 4 PULSE (data 1..4), then LINE_SYNC. Expect WE at addresses 0..3 with data 1..4, then LINE_READY, READY_PAGE=0, READY_LINE=0, STATUS=000, PAGES_USED=1.
2. Three full lines with no RD_RELEASE. Expect line 0 on page 0, line 1 on page 1, line 2 as LINE_DROPPED, DROP_CNT=1, FRAME_DONE with that drop, and no WE during line 2.
3. A line with 3 pixels, then a line with 6 pixels, the 2nd pixel with PIXEL_ERROR. Expect STATUS=010 for the first; 4 writes and STATUS=101 for the second.
4. PAGES_USED=2, RD_RELEASE coincident with LINE_SYNC of a dropped line. Expect PAGES_USED=1 and the next line is written to page 0.
5. FRAME_SYNC after 2 pixels of a line. Expect no LINE_READY, pix_cnt restarts, the next write goes to address {wr_page,0}, DROP_CNT=0.
6. RESET asserted while WE=1. Expect all outputs 0 asynchronously, PAGES_USED=0, and PULSE ignored until FRAME_SYNC.
